// File: rtl/regfile_access_seq_pkg.sv
// Shared definitions for the register-file access sequencer: state encoding,
// request opcodes and parameter defaults.
package regfile_access_seq_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 3;
    localparam int PARK_REG_DEF = 0;
    localparam int CNT_W_DEF    = 8;

    // Value of req_write selecting the request kind.
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Sequencer states. Encoding is fixed so checkers can decode the debug port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_CAP  = 3'd2,
        ST_RSP     = 3'd3,
        ST_WR      = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_access_seq.sv
// Initiator side of the register-file interface. Takes one read-pair or write
// request at a time, sequences it onto the register file ports and returns read
// data. The register file writes every clock, so the write port is parked on a
// sink register (hardwired zero) whenever no write is in flight.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are
// both high. The producer holds valid and payload stable until that edge; ready
// may be high with valid low and is then ignored. Here req_ready is high only in
// IDLE, and rsp_valid with its data stays stable until rsp_ready is seen.
module regfile_access_seq
    import regfile_access_seq_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int PARK_REG = PARK_REG_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    // request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_ra1,
    input  logic [ADDR_W-1:0] req_ra2,
    input  logic [ADDR_W-1:0] req_wa,
    input  logic [DATA_W-1:0] req_wd,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rd1,
    output logic [DATA_W-1:0] rsp_rd2,
    // register file ports
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    // statistics and debug
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output state_t            dbg_state
);

    localparam logic [ADDR_W-1:0] LP_PARK = ADDR_W'(PARK_REG);

    state_t              r_state;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rd1;
    logic [DATA_W-1:0]   r_rsp_rd2;
    logic [ADDR_W-1:0]   r_rd_reg1;
    logic [ADDR_W-1:0]   r_rd_reg2;
    logic [ADDR_W-1:0]   r_wr_reg;
    logic [DATA_W-1:0]   r_wr_data;
    logic [CNT_W-1:0]    r_rd_count;
    logic [CNT_W-1:0]    r_wr_count;

    // Sequencer FSM with all outputs registered; the request payload is latched
    // straight into the register-file port registers at the accept edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rd1   <= '0;
            r_rsp_rd2   <= '0;
            r_rd_reg1   <= '0;
            r_rd_reg2   <= '0;
            r_wr_reg    <= LP_PARK;
            r_wr_data   <= '0;
            r_rd_count  <= '0;
            r_wr_count  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        if (req_write == OP_WRITE) begin
                            // Write port leaves the park register for exactly the WR cycle.
                            r_wr_reg  <= req_wa;
                            r_wr_data <= req_wd;
                            r_state   <= ST_WR;
                        end else begin
                            r_rd_reg1 <= req_ra1;
                            r_rd_reg2 <= req_ra2;
                            r_state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    // Addresses are on the register file; give its read path a cycle.
                    r_state <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    r_rsp_rd1   <= rf_read_data1;
                    r_rsp_rd2   <= rf_read_data2;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rd_count  <= r_rd_count + CNT_W'(1);
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    // The register file commits wa/wd on this edge; park again.
                    r_wr_reg    <= LP_PARK;
                    r_wr_data   <= '0;
                    r_wr_count  <= r_wr_count + CNT_W'(1);
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_wr_reg    <= LP_PARK;
                    r_wr_data   <= '0;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rd1       = r_rsp_rd1;
    assign rsp_rd2       = r_rsp_rd2;
    assign rf_read_reg1  = r_rd_reg1;
    assign rf_read_reg2  = r_rd_reg2;
    assign rf_write_reg  = r_wr_reg;
    assign rf_write_data = r_wr_data;
    assign rd_count      = r_rd_count;
    assign wr_count      = r_wr_count;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_regfile_access_seq.sv
// Bench for regfile_access_seq driving a behavioural 8 x 16 register file
// (register 0 hardwired to zero, written every clock, combinational read).
module tb_regfile_access_seq;
    import regfile_access_seq_pkg::*;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int CW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_ra1, req_ra2, req_wa;
    logic [DW-1:0] req_wd;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rd1, rsp_rd2;
    logic [AW-1:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
    logic [DW-1:0] rf_write_data, rf_read_data1, rf_read_data2;
    logic [CW-1:0] rd_count, wr_count;
    state_t        dbg_state;

    regfile_access_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_ra1(req_ra1), .req_ra2(req_ra2), .req_wa(req_wa), .req_wd(req_wd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .rd_count(rd_count), .wr_count(wr_count), .dbg_state(dbg_state)
    );

    // ---------------- register file ----------------
    logic [DW-1:0] rf_mem [8];
    initial begin
        rf_mem[0] = 16'h0000; rf_mem[1] = 16'h1111; rf_mem[2] = 16'h2222;
        rf_mem[3] = 16'h3333; rf_mem[4] = 16'h4444; rf_mem[5] = 16'h0007;
        rf_mem[6] = 16'h6666; rf_mem[7] = 16'h7777;
    end
    always @(posedge clk) if (rf_write_reg != 3'd0) rf_mem[rf_write_reg] <= rf_write_data;
    assign rf_read_data1 = rf_mem[rf_read_reg1];
    assign rf_read_data2 = rf_mem[rf_read_reg2];

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [2*DW-1:0] exp_q[$];
    int exp_rd = 0;
    int exp_wr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a response handshake will happen on the next rising edge.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got %h/%h expected none", rsp_rd1, rsp_rd2);
            end else begin
                logic [2*DW-1:0] e;
                e = exp_q.pop_front();
                check("rsp_data", {16'h0, rsp_rd1, rsp_rd2} >> 0 == 0 ? 32'h0 : {rsp_rd1, rsp_rd2}, e);
            end
        end
    end

    // ---------------- driver tasks (all start and end at posedge+1) ----------------
    task automatic send_req(input logic w, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        int n;
        n = 0;
        req_valid = 1'b1; req_write = w;
        req_ra1 = ra1; req_ra2 = ra2; req_wa = wa; req_wd = wd;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) check("req_accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_ra1 = '0; req_ra2 = '0; req_wa = '0; req_wd = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        send_req(OP_WRITE, 3'd0, 3'd0, wa, wd);
        check("wr_state", 32'(dbg_state), 32'(ST_WR));
        check("wr_port_addr", 32'(rf_write_reg), 32'(wa));
        check("wr_port_data", 32'(rf_write_data), 32'(wd));
        @(posedge clk); #1;
        exp_wr = (exp_wr + 1) % 256;
        check("wr_park_addr", 32'(rf_write_reg), 32'd0);
        check("wr_park_data", 32'(rf_write_data), 32'd0);
        check("wr_committed", 32'(rf_mem[wa]), (wa == 3'd0) ? 32'd0 : 32'(wd));
        check("wr_count", 32'(wr_count), 32'(exp_wr));
        check("wr_req_ready", 32'(req_ready), 32'd1);
    endtask

    // Response rises on the third edge counting the accept edge (accept, RD_ADDR
    // exit, RD_CAP exit), then is held for 'hold' cycles before rsp_ready.
    task automatic do_read(input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                           input logic [DW-1:0] e1, input logic [DW-1:0] e2, input int hold);
        int n;
        exp_q.push_back({e1, e2});
        send_req(OP_READ, ra1, ra2, 3'd0, 16'h0);
        check("rd_addr1", 32'(rf_read_reg1), 32'(ra1));
        check("rd_addr2", 32'(rf_read_reg2), 32'(ra2));
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rd_latency", 32'(n), 32'd2);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rd1", 32'(rsp_rd1), 32'(e1));
            check("bp_rd2", 32'(rsp_rd2), 32'(e2));
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_wr_park", 32'(rf_write_reg), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        exp_rd = (exp_rd + 1) % 256;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("rd_count", 32'(rd_count), 32'(exp_rd));
        check("rd_idle", 32'(dbg_state), 32'(ST_IDLE));
    endtask

    // ---------------- stimulus ----------------
    logic [DW-1:0] snap [8];

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_ra1 = '0; req_ra2 = '0;
        req_wa = '0; req_wd = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset values
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rd1", 32'(rsp_rd1), 32'd0);
        check("rst_rsp_rd2", 32'(rsp_rd2), 32'd0);
        check("rst_rd_reg1", 32'(rf_read_reg1), 32'd0);
        check("rst_rd_reg2", 32'(rf_read_reg2), 32'd0);
        check("rst_wr_reg", 32'(rf_write_reg), 32'd0);
        check("rst_wr_data", 32'(rf_write_data), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // idle for 10 cycles: write port parked, registers untouched
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_park", 32'(rf_write_reg), 32'd0);
        end
        check("idle_r1", 32'(rf_mem[1]), 32'h1111);
        check("idle_r5", 32'(rf_mem[5]), 32'h0007);
        check("idle_r7", 32'(rf_mem[7]), 32'h7777);

        // reset while in RD_CAP aborts the read; no response is expected
        send_req(OP_READ, 3'd2, 3'd3, 3'd0, 16'h0);
        @(posedge clk); #1;
        check("abort_in_cap", 32'(dbg_state), 32'(ST_RD_CAP));
        reset = 1'b1;
        #1;
        check("abort_async_state", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_async_valid", 32'(rsp_valid), 32'd0);
        check("abort_async_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_rd_count", 32'(rd_count), 32'd0);
        check("abort_wr_count", 32'(wr_count), 32'd0);

        // write r2=20 then read (r2,r0)
        do_write(3'd2, 16'd20);
        do_read(3'd2, 3'd0, 16'd20, 16'd0, 0);
        check("cnt_wr_1", 32'(wr_count), 32'd1);
        check("cnt_rd_1", 32'(rd_count), 32'd1);

        // back-to-back write r4=1, read (r4,r5) with r5 holding 7
        do_write(3'd4, 16'd1);
        do_read(3'd4, 3'd5, 16'd1, 16'd7, 0);

        // backpressure: rsp_ready low for 5 cycles
        do_read(3'd2, 3'd4, 16'd20, 16'd1, 5);

        // all-ones data, distinct addresses
        do_write(3'd7, 16'hFFFF);
        do_read(3'd7, 3'd3, 16'hFFFF, 16'h3333, 2);

        // write aimed at the park register is executed and counted but has no effect
        do_write(3'd0, 16'hBEEF);
        do_read(3'd0, 3'd7, 16'h0000, 16'hFFFF, 0);

        // rsp_ready while no response is pending is ignored
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("idle_rsp_ready_rd_count", 32'(rd_count), 32'd5);
        check("idle_rsp_ready_state", 32'(dbg_state), 32'(ST_IDLE));

        // wr_count wrap: keep writing the park register until 255, then one more
        for (int i = 1; i < 8; i++) snap[i] = rf_mem[i];
        while (exp_wr != 255) do_write(3'd0, DW'($urandom_range(1, 16'hFFFF)));
        check("wrap_at_255", 32'(wr_count), 32'd255);
        do_write(3'd0, 16'h5A5A);
        check("wrap_to_0", 32'(wr_count), 32'd0);
        for (int i = 1; i < 8; i++) check("park_no_disturb", 32'(rf_mem[i]), 32'(snap[i]));

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
